// File: rtl/gradient_scheduler.sv
// Frame sequencer for the Sobel gradient stage: walks the anchor window across the
// image, fetches each tile, kicks the gradient stage and hands results downstream.
module gradient_scheduler #(
  parameter int IMG_W     = 640,
  parameter int IMG_H     = 480,
  parameter int TILE_COLS = 14,
  parameter int TIMEOUT   = 64
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        start,
  output logic        fetch_req,
  output logic [31:0] fetch_x,
  output logic [31:0] fetch_y,
  input  logic        fetch_ack,
  output logic        anchor_moving,
  output logic [31:0] anchor_x,
  output logic [31:0] anchor_y,
  input  logic        gradient_final,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        frame_done,
  output logic        timeout_err,
  output logic [2:0]  state_dbg
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FETCH     = 3'd1;
  localparam logic [2:0] S_MOVE      = 3'd2;
  localparam logic [2:0] S_WAIT_GRAD = 3'd3;
  localparam logic [2:0] S_EMIT      = 3'd4;
  localparam logic [2:0] S_ADVANCE   = 3'd5;
  localparam logic [2:0] S_DONE      = 3'd6;

  localparam logic [31:0] X_LAST  = 32'(IMG_W - 2);
  localparam logic [31:0] Y_LAST  = 32'(IMG_H - 2);
  localparam logic [31:0] X_STEP  = 32'(TILE_COLS);
  localparam logic [31:0] WD_LAST = 32'(TIMEOUT - 1);

  logic [2:0]  state;
  logic [31:0] wd_cnt;

  // Handshakes: a request (fetch_req / out_valid) is raised by the scheduler and held,
  // with its coordinates frozen, until a cycle in which the matching response
  // (fetch_ack / out_ready) is also 1; that cycle is the transfer.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= S_IDLE;
      anchor_x    <= '0;
      anchor_y    <= '0;
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            anchor_x    <= 32'd1;
            anchor_y    <= 32'd1;
            timeout_err <= 1'b0;
            state       <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (fetch_ack) state <= S_MOVE;
        end
        S_MOVE: begin
          wd_cnt <= '0;
          state  <= S_WAIT_GRAD;
        end
        S_WAIT_GRAD: begin
          if (gradient_final) begin
            state <= S_EMIT;
          end else if (wd_cnt == WD_LAST) begin
            timeout_err <= 1'b1;
            state       <= S_IDLE;
          end else begin
            wd_cnt <= wd_cnt + 32'd1;
          end
        end
        S_EMIT: begin
          if (out_ready) state <= S_ADVANCE;
        end
        S_ADVANCE: begin
          // The last tile of a row may overhang the image; padding is handled downstream.
          if (anchor_x + X_STEP <= X_LAST) begin
            anchor_x <= anchor_x + X_STEP;
            state    <= S_FETCH;
          end else if (anchor_y < Y_LAST) begin
            anchor_x <= 32'd1;
            anchor_y <= anchor_y + 32'd1;
            state    <= S_FETCH;
          end else begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign fetch_req     = (state == S_FETCH);
  assign fetch_x       = fetch_req ? anchor_x : '0;
  assign fetch_y       = fetch_req ? anchor_y : '0;
  assign anchor_moving = (state == S_MOVE);
  assign out_valid     = (state == S_EMIT);
  assign busy          = (state != S_IDLE) && (state != S_DONE);
  assign frame_done    = (state == S_DONE);
  assign state_dbg     = state;

endmodule

// File: doc/gradient_scheduler.md
Name: gradient_scheduler

Overview:
Sequences the Sobel gradient stage across a full frame. It walks a 16-column by 3-row anchor window over the image and requests each pixel tile from the line-buffer/memory side. For each tile it pulses the gradient stage's anchor_moving, waits for gradient_final, and hands the completed tile to the downstream non-max-suppression stage through a valid/ready handshake. It sits between the frame-level control FSM and gradient_controller.

Parameters:
IMG_W, 640, image width in pixels (min 16)
IMG_H, 480, image height in pixels (min 3)
TILE_COLS, 14, output columns produced per anchor (input tile is TILE_COLS+2 wide)
TIMEOUT, 64, max cycles to wait for gradient_final before aborting

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse: begin a frame
fetch_req  out  1  request tile centred at (fetch_x, fetch_y) from buffer
fetch_x  out  32  anchor column of requested tile
fetch_y  out  32  anchor row of requested tile
fetch_ack  in  1  tile data valid on gradient_in this cycle
anchor_moving  out  1  one-cycle pulse to gradient stage: new tile loaded
anchor_x  out  32  current anchor column, to gradient stage
anchor_y  out  32  current anchor row
gradient_final  in  1  gradient stage has finished the current tile
out_valid  out  1  gradient results for (anchor_x, anchor_y) are stable
out_ready  in  1  downstream accepts tile
busy  out  1  frame in progress
frame_done  out  1  one-cycle pulse after the last tile is accepted
timeout_err  out  1  sticky: gradient stage timed out; cleared by start

Behaviour:
- Clock and reset: single clock clk; reset n_rst is asynchronous and active-low. In reset, every output is 0 and the FSM is in IDLE.
- States: IDLE, FETCH, MOVE, WAIT_GRAD, EMIT, ADVANCE, DONE.
- IDLE:
  - start=1 loads anchor_x=1, anchor_y=1, clears timeout_err, sets busy, and goes to FETCH.
  - start is ignored in every other state.
- FETCH:
  - fetch_req=1, with fetch_x/fetch_y equal to anchor_x/anchor_y.
  - Stays in FETCH until fetch_ack=1, then goes to MOVE. fetch_ack may arrive in the first FETCH cycle.
  - fetch_ack outside FETCH is ignored.
- MOVE: anchor_moving=1 for exactly one cycle, watchdog counter cleared, then WAIT_GRAD.
- WAIT_GRAD:
  - Watchdog counts each cycle.
  - gradient_final=1 goes to EMIT.
  - Counter reaching TIMEOUT without gradient_final sets timeout_err, clears busy, and returns to IDLE with no frame_done.
  - gradient_final asserted in any other state is ignored.
- EMIT:
  - out_valid=1, held until out_ready=1.
  - Transfer occurs in a cycle where out_valid and out_ready are both 1; then ADVANCE.
  - anchor_x/anchor_y stay stable while out_valid=1.
- ADVANCE (one cycle):
  - If anchor_x+TILE_COLS <= IMG_W-2: anchor_x += TILE_COLS, then FETCH.
  - Else if anchor_y < IMG_H-2: anchor_x=1, anchor_y += 1, then FETCH.
  - Else go to DONE.
- DONE: frame_done=1 for one cycle, busy=0, then IDLE.
- Last tile in a row may extend past column IMG_W-2. The buffer pads those columns and downstream discards them; the scheduler does not truncate.
- Tiles per frame: ceil((IMG_W-2)/TILE_COLS)*(IMG_H-2).
- Minimum per-tile latency: FETCH(1)+MOVE(1)+gradient latency+EMIT(1)+ADVANCE(1).
- Reset mid-frame returns to IDLE immediately, with all outputs 0 and no frame_done.
- Arithmetic: all counters unsigned 32-bit, and compares are done without overflow (IMG_W, IMG_H < 2^16).

Test Plan:
1. IMG_W=32, IMG_H=5; start; fetch_ack and out_ready tied 1; gradient_final 3 cycles after anchor_moving -> 9 tiles at anchor_x sequence 1,15,29 for each of rows 1,2,3, exactly 9 anchor_moving pulses, then frame_done 1 cycle, busy=0.
2. fetch_ack delayed 5 cycles on tile 2 -> fetch_req held high 5 cycles with fetch_x=15, fetch_y=1 stable, and no anchor_moving until the cycle after ack.
3. out_ready held low 4 cycles on tile 1 -> out_valid stays 1 with anchor_x=1 frozen, and the next fetch_req appears 2 cycles after out_ready rises.
4. gradient_final never asserted with TIMEOUT=64 -> timeout_err=1 and busy=0 exactly 64 cycles after the WAIT_GRAD entry; no frame_done; a subsequent start clears timeout_err.
5. n_rst pulsed low during WAIT_GRAD of tile 4 -> all outputs 0 asynchronously; a following start restarts at anchor (1,1).
6. start pulsed again mid-frame, plus a spurious gradient_final during FETCH -> both ignored; the tile sequence and count are identical to scenario 1.
